// File: rtl/hub75_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hub75_pkg
// Brief    : Shared register map, pixel type, fill FSM states and the
//            back-buffer pixel index helper for the HUB75 fill engine.
// Revision : 1.0
// ============================================================================
package hub75_pkg;

    localparam logic [1:0] c_REG_CTRL   = 2'd0;
    localparam logic [1:0] c_REG_RECT   = 2'd1;
    localparam logic [1:0] c_REG_COLOR  = 2'd2;
    localparam logic [1:0] c_REG_STATUS = 2'd3;

    localparam int c_CTRL_START = 0;
    localparam int c_CTRL_SWAP  = 1;
    localparam int c_CTRL_BUF   = 2;

    localparam int c_STAT_BUSY = 0;
    localparam int c_STAT_DONE = 1;
    localparam int c_STAT_ERR  = 2;

    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } hub75_pixel_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_GAP   = 3'd2,
        ST_SWAP  = 3'd3,
        ST_DONE  = 3'd4
    } fill_state_t;

    // Index = {buf, y, x}; y's MSB picks the panel half, the rest the row pair.
    function automatic logic [31:0] hub75_pixel_index(
        input logic       buf_sel,
        input logic [7:0] x,
        input logic [7:0] y,
        input int         xbits,
        input int         ybits
    );
        logic [31:0] xm;
        logic [31:0] ym;
        xm = {24'd0, x} & ((32'd1 << xbits) - 32'd1);
        ym = {24'd0, y} & ((32'd1 << ybits) - 32'd1);
        return ({31'd0, buf_sel} << (xbits + ybits)) | (ym << xbits) | xm;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hub75_rect_walker.sv
`default_nettype none
// ============================================================================
// Module   : hub75_rect_walker
// Brief    : Clips a rectangle to the panel and walks it row-major.
// Revision : 1.0
// ============================================================================
module hub75_rect_walker #(
    parameter int ROWS = 64,
    parameter int COLS = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic       i_step,
    input  logic [7:0] i_x0,
    input  logic [7:0] i_y0,
    input  logic [7:0] i_w,
    input  logic [7:0] i_h,
    output logic [7:0] o_x,
    output logic [7:0] o_y,
    output logic       o_empty,
    output logic       o_last
);

    localparam logic [8:0] c_COLS = 9'(COLS);
    localparam logic [8:0] c_ROWS = 9'(ROWS);

    logic [8:0] w_xsum;
    logic [8:0] w_ysum;
    logic [8:0] w_x1;
    logic [8:0] w_y1;
    logic       w_row_end;
    logic [7:0] r_x0;
    logic [7:0] r_x;
    logic [7:0] r_y;
    logic [8:0] r_x1;
    logic [8:0] r_y1;

    always_comb begin
        w_xsum    = {1'b0, i_x0} + {1'b0, i_w};
        w_ysum    = {1'b0, i_y0} + {1'b0, i_h};
        w_x1      = (w_xsum > c_COLS) ? c_COLS : w_xsum;
        w_y1      = (w_ysum > c_ROWS) ? c_ROWS : w_ysum;
        // Covers x0/y0 off-panel as well as a zero width or height.
        o_empty   = (w_x1 <= {1'b0, i_x0}) || (w_y1 <= {1'b0, i_y0});
        w_row_end = (({1'b0, r_x} + 9'd1) == r_x1);
        o_last    = w_row_end && (({1'b0, r_y} + 9'd1) == r_y1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x0 <= 8'd0;
            r_x  <= 8'd0;
            r_y  <= 8'd0;
            r_x1 <= 9'd0;
            r_y1 <= 9'd0;
        end else if (i_load) begin
            r_x0 <= i_x0;
            r_x  <= i_x0;
            r_y  <= i_y0;
            r_x1 <= w_x1;
            r_y1 <= w_y1;
        end else if (i_step) begin
            if (w_row_end) begin
                r_x <= r_x0;
                r_y <= r_y + 8'd1;
            end else begin
                r_x <= r_x + 8'd1;
            end
        end
    end

    assign o_x = r_x;
    assign o_y = r_y;

endmodule
`default_nettype wire

// File: rtl/hub75_fill_engine.sv
`default_nettype none
// ============================================================================
// Module   : hub75_fill_engine
// Brief    : Register-programmed rectangle fill master for the HUB75 driver.
// Revision : 1.0
// ============================================================================
module hub75_fill_engine
    import hub75_pkg::*;
#(
    parameter int          ROWS           = 64,
    parameter int          COLS           = 64,
    parameter logic [31:0] CFG_BASEADDR   = 32'h81010000,
    parameter logic [31:0] HUB75_BASEADDR = 32'h81000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        wen,
    input  logic        ren,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        active,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wmask,
    output logic        m_wen,
    input  logic        m_ready,
    output logic        busy
);

    localparam int          c_XBITS     = $clog2(COLS);
    localparam int          c_YBITS     = $clog2(ROWS);
    localparam logic [31:0] c_SWAP_ADDR = HUB75_BASEADDR + 32'(8 * ROWS * COLS);

    fill_state_t  r_state;
    fill_state_t  w_next;
    logic         r_first;
    logic [31:0]  r_rect;
    logic [23:0]  r_color;
    logic         r_cfg_swap;
    logic         r_cfg_buf;
    logic         r_done;
    logic         r_err;
    hub75_pixel_t r_snap_color;
    logic         r_snap_swap;
    logic         r_snap_buf;
    logic [31:0]  r_rdata;
    logic         r_ready;

    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_status;
    logic [2:0]  w_ctrl_bits;
    logic        w_start;
    logic        w_accept;
    logic        w_load;
    logic        w_step;
    logic [7:0]  w_x;
    logic [7:0]  w_y;
    logic        w_empty;
    logic        w_last;
    logic [31:0] w_index;
    logic [31:0] w_rd;
    logic        w_unused;

    assign active      = (addr[31:4] == CFG_BASEADDR[31:4]);
    assign w_wr        = wen && active;
    assign w_wr_ctrl   = w_wr && (addr[3:2] == c_REG_CTRL);
    assign w_wr_status = w_wr && (addr[3:2] == c_REG_STATUS);
    // The START write itself may also set SWAP_AFTER/TARGET_BUF for this fill.
    assign w_ctrl_bits = wmask[0] ? wdata[2:0] : {r_cfg_buf, r_cfg_swap, 1'b0};
    assign w_start     = w_wr_ctrl && w_ctrl_bits[c_CTRL_START];
    assign w_accept    = w_start && (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign w_index     = hub75_pixel_index(r_snap_buf, w_x, w_y, c_XBITS, c_YBITS);
    assign w_unused    = &{1'b0, addr[1:0], 1'b0};

    hub75_rect_walker #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_walker (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_step  (w_step),
        .i_x0    (r_rect[7:0]),
        .i_y0    (r_rect[15:8]),
        .i_w     (r_rect[23:16]),
        .i_h     (r_rect[31:24]),
        .o_x     (w_x),
        .o_y     (w_y),
        .o_empty (w_empty),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_first <= 1'b0;
        end else begin
            r_state <= w_next;
            r_first <= (w_next != r_state);
        end
    end

    // m_ready is ignored in the first WRITE/SWAP cycle: it may still be stale.
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_step  = 1'b0;
        m_wen   = 1'b0;
        m_addr  = 32'd0;
        m_wdata = 32'd0;
        m_wmask = 4'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_load = 1'b1;
                    if (!w_empty)
                        w_next = ST_WRITE;
                    else if (w_ctrl_bits[c_CTRL_SWAP])
                        w_next = ST_SWAP;
                    else
                        w_next = ST_DONE;
                end
            end
            ST_WRITE: begin
                m_wen   = 1'b1;
                m_addr  = HUB75_BASEADDR + (w_index << 2);
                m_wdata = {8'h00, r_snap_color};
                m_wmask = 4'b0111;
                if (!r_first && m_ready)
                    w_next = ST_GAP;
            end
            ST_GAP: begin
                if (!w_last) begin
                    w_step = 1'b1;
                    w_next = ST_WRITE;
                end else begin
                    w_next = r_snap_swap ? ST_SWAP : ST_DONE;
                end
            end
            ST_SWAP: begin
                m_wen   = 1'b1;
                m_addr  = c_SWAP_ADDR;
                m_wdata = {31'd0, r_snap_buf};
                m_wmask = 4'b0001;
                if (!r_first && m_ready)
                    w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rect       <= 32'd0;
            r_color      <= 24'd0;
            r_cfg_swap   <= 1'b0;
            r_cfg_buf    <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_snap_color <= '0;
            r_snap_swap  <= 1'b0;
            r_snap_buf   <= 1'b0;
        end else begin
            if (w_wr && (addr[3:2] == c_REG_RECT)) begin
                for (int i = 0; i < 4; i++)
                    if (wmask[i]) r_rect[8*i +: 8] <= wdata[8*i +: 8];
            end
            if (w_wr && (addr[3:2] == c_REG_COLOR)) begin
                for (int i = 0; i < 3; i++)
                    if (wmask[i]) r_color[8*i +: 8] <= wdata[8*i +: 8];
            end
            if (w_wr_ctrl) begin
                r_cfg_swap <= w_ctrl_bits[c_CTRL_SWAP];
                r_cfg_buf  <= w_ctrl_bits[c_CTRL_BUF];
            end
            if (w_accept) begin
                r_snap_color <= r_color;
                r_snap_swap  <= w_ctrl_bits[c_CTRL_SWAP];
                r_snap_buf   <= w_ctrl_bits[c_CTRL_BUF];
            end
            if (r_state == ST_DONE)
                r_done <= 1'b1;
            else if (w_wr_status && wmask[0] && wdata[c_STAT_DONE])
                r_done <= 1'b0;
            if (w_start && busy)
                r_err <= 1'b1;
            else if (w_wr_status && wmask[0] && wdata[c_STAT_ERR])
                r_err <= 1'b0;
        end
    end

    always_comb begin
        w_rd = 32'd0;
        case (addr[3:2])
            c_REG_CTRL: begin
                w_rd[c_CTRL_SWAP] = r_cfg_swap;
                w_rd[c_CTRL_BUF]  = r_cfg_buf;
            end
            c_REG_RECT:  w_rd = r_rect;
            c_REG_COLOR: w_rd = {8'd0, r_color};
            default: begin
                w_rd[c_STAT_BUSY] = busy;
                w_rd[c_STAT_DONE] = r_done;
                w_rd[c_STAT_ERR]  = r_err;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 32'd0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= active && (ren || wen);
            r_rdata <= (active && ren) ? w_rd : 32'd0;
        end
    end

    assign rdata = r_rdata;
    assign ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_hub75_fill_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_hub75_fill_engine
// Brief    : Self-checking bench: directed and random fills vs. a pixel list model.
// Revision : 1.0
// ============================================================================
module tb_hub75_fill_engine;

    localparam int          ROWS = 64;
    localparam int          COLS = 64;
    localparam logic [31:0] CFG  = 32'h81010000;
    localparam logic [31:0] HUB  = 32'h81000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wmask = '0;
    logic        wen = 1'b0;
    logic        ren = 1'b0;
    logic [31:0] rdata;
    logic        ready;
    logic        active;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wmask;
    logic        m_wen;
    logic        m_ready = 1'b0;
    logic        busy;

    hub75_fill_engine #(
        .ROWS (ROWS), .COLS (COLS), .CFG_BASEADDR (CFG), .HUB75_BASEADDR (HUB)
    ) dut (
        .clk (clk), .rst (rst), .addr (addr), .wdata (wdata), .wmask (wmask),
        .wen (wen), .ren (ren), .rdata (rdata), .ready (ready), .active (active),
        .m_addr (m_addr), .m_wdata (m_wdata), .m_wmask (m_wmask), .m_wen (m_wen),
        .m_ready (m_ready), .busy (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] cap_a[$];
    logic [31:0] cap_d[$];
    logic [3:0]  cap_m[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    logic [3:0]  exp_m[$];

    int          wr_idx = 0;
    int          stall_idx = -1;
    int          stall_len = 0;
    bit          rand_rdy = 1'b0;
    int          cur_delay = 0;
    int          hi_cnt = 0;
    int          lo_cnt = 0;
    int          stab_err = 0;
    int          gap_err = 0;
    int          stall_hi = 0;
    bit          first_wr = 1'b1;
    bit          prev_wen = 1'b0;
    logic [31:0] prev_a = '0;
    logic [31:0] prev_d = '0;

    // Driver-side responder and write monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (m_wen) begin
                if (!prev_wen) begin
                    cap_a.push_back(m_addr);
                    cap_d.push_back(m_wdata);
                    cap_m.push_back(m_wmask);
                    if (!first_wr && lo_cnt != 1) gap_err++;
                    first_wr  = 1'b0;
                    cur_delay = rand_rdy ? int'($urandom_range(0, 3)) :
                                (wr_idx == stall_idx ? stall_len : 0);
                    wr_idx++;
                    hi_cnt = 0;
                end else if (m_addr !== prev_a || m_wdata !== prev_d) begin
                    stab_err++;
                end
                hi_cnt++;
                if (wr_idx - 1 == stall_idx) stall_hi = hi_cnt;
                m_ready = (hi_cnt > cur_delay);
                lo_cnt  = 0;
            end else begin
                m_ready = 1'b0;
                lo_cnt++;
            end
            prev_wen = m_wen;
            prev_a   = m_addr;
            prev_d   = m_wdata;
        end
    end

    task automatic clear_mon();
        cap_a.delete(); cap_d.delete(); cap_m.delete();
        wr_idx = 0; first_wr = 1'b1; stab_err = 0; gap_err = 0; stall_hi = 0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        addr = a; wdata = d; wmask = m; wen = 1'b1;
        @(negedge clk);
        wen = 1'b0; addr = '0; wdata = '0; wmask = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; ren = 1'b1;
        @(negedge clk);
        d = rdata; ren = 1'b0; addr = '0;
    endtask

    // Expected pixel list straight from the clipping and addressing rules.
    task automatic model_fill(input int x0, input int y0, input int w, input int h,
                              input logic [31:0] col, input bit tbuf, input bit sw);
        int x1, y1;
        exp_a.delete(); exp_d.delete(); exp_m.delete();
        x1 = (x0 + w > COLS) ? COLS : x0 + w;
        y1 = (y0 + h > ROWS) ? ROWS : y0 + h;
        for (int y = y0; y < y1; y++)
            for (int x = x0; x < x1; x++) begin
                exp_a.push_back(HUB + 32'(4 * (int'(tbuf) * ROWS * COLS + y * COLS + x)));
                exp_d.push_back(col & 32'h00FF_FFFF);
                exp_m.push_back(4'b0111);
            end
        if (sw) begin
            exp_a.push_back(HUB + 32'(8 * ROWS * COLS));
            exp_d.push_back({31'd0, tbuf});
            exp_m.push_back(4'b0001);
        end
    endtask

    task automatic start_fill(input int x0, input int y0, input int w, input int h,
                              input logic [31:0] col, input bit tbuf, input bit sw);
        bus_write(CFG + 32'd4, {8'(h), 8'(w), 8'(y0), 8'(x0)}, 4'hF);
        bus_write(CFG + 32'd8, col, 4'hF);
        clear_mon();
        bus_write(CFG, {29'd0, tbuf, sw, 1'b1}, 4'h1);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (m_wen !== 1'b0) begin n_err++; $display("FAIL rst_m_wen got %b want 0", m_wen); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
        n_vec++; if ({ready, rdata, m_addr, m_wdata, m_wmask} !== '0) begin
            n_err++; $display("FAIL rst_outputs got %h/%h/%h/%h/%h want 0", ready, rdata, m_addr, m_wdata, m_wmask);
        end
        rst = 1'b0;
        bus_read(CFG + 32'd12, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL rst_status got %h want 0", d); end
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL read_ready got %b want 1", ready); end
        bus_read(CFG + 32'd4, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL rst_rect got %h want 0", d); end
        addr = CFG + 32'd12; #1;
        n_vec++; if (active !== 1'b1) begin n_err++; $display("FAIL active_in got %b want 1", active); end
        addr = CFG + 32'd16; #1;
        n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL active_out got %b want 0", active); end
        addr = '0;
    endtask

    task automatic test_fill(input string name, input int x0, input int y0, input int w,
                             input int h, input logic [31:0] col, input bit tbuf, input bit sw);
        bit ok;
        logic [31:0] d;
        model_fill(x0, y0, w, h, col, tbuf, sw);
        start_fill(x0, y0, w, h, col, tbuf, sw);
        wait_idle(ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL %s_timeout busy still %b want 0", name, busy); end
        n_vec++; if (cap_a.size() != exp_a.size()) begin
            n_err++; $display("FAIL %s_count got %0d want %0d", name, cap_a.size(), exp_a.size());
        end
        for (int i = 0; i < exp_a.size() && i < cap_a.size(); i++) begin
            n_vec++;
            if ({cap_a[i], cap_d[i], cap_m[i]} !== {exp_a[i], exp_d[i], exp_m[i]}) begin
                n_err++;
                $display("FAIL %s_wr%0d got %h/%h/%b want %h/%h/%b", name, i,
                         cap_a[i], cap_d[i], cap_m[i], exp_a[i], exp_d[i], exp_m[i]);
            end
        end
        n_vec++; if (stab_err != 0 || gap_err != 0) begin
            n_err++; $display("FAIL %s_handshake got stab=%0d gap=%0d want 0/0", name, stab_err, gap_err);
        end
        bus_read(CFG + 32'd8, d);
        n_vec++; if (d !== (col & 32'h00FF_FFFF)) begin n_err++; $display("FAIL %s_color_rd got %h want %h", name, d, col & 32'h00FF_FFFF); end
        bus_read(CFG, d);
        n_vec++; if (d !== {29'd0, tbuf, sw, 1'b0}) begin n_err++; $display("FAIL %s_ctrl_rd got %h want %h", name, d, {29'd0, tbuf, sw, 1'b0}); end
        bus_read(CFG + 32'd12, d);
        n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL %s_status got %h want 2", name, d); end
        bus_write(CFG + 32'd12, 32'h2, 4'h1);
    endtask

    task automatic test_basic();
        test_fill("basic", 1, 31, 1, 2, 32'h00112233, 1'b0, 1'b0);
        n_vec++; if (cap_a.size() < 2 || cap_a[0] !== 32'h81001F04 || cap_a[1] !== 32'h81002004) begin
            n_err++; $display("FAIL basic_addrs got %0d writes, want 81001f04,81002004", cap_a.size());
        end
    endtask

    task automatic test_swap();
        test_fill("swap", 1, 31, 1, 2, 32'h00112233, 1'b1, 1'b1);
        n_vec++; if (cap_a.size() != 3 || cap_a[0] !== 32'h81005F04 || cap_a[1] !== 32'h81006004 ||
                     cap_a[2] !== 32'h81008000 || cap_d[2] !== 32'h1 || cap_m[2] !== 4'b0001) begin
            n_err++; $display("FAIL swap_seq got %0d writes, want 81005f04,81006004,81008000/1/0001", cap_a.size());
        end
    endtask

    task automatic test_clip();
        test_fill("clip", 62, 0, 10, 1, 32'h00A0B0C0, 1'b0, 1'b0);
        n_vec++; if (cap_a.size() != 2 || cap_a[0] !== 32'h810000F8 || cap_a[1] !== 32'h810000FC) begin
            n_err++; $display("FAIL clip_addrs got %0d writes, want 810000f8,810000fc", cap_a.size());
        end
    endtask

    task automatic test_empty();
        logic [31:0] d;
        bit ok;
        start_fill(5, 5, 0, 4, 32'h00123456, 1'b0, 1'b0);
        bus_read(CFG + 32'd12, d);
        n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL empty_status got %h want 2", d); end
        wait_idle(ok);
        repeat (5) @(negedge clk);
        n_vec++; if (cap_a.size() != 0 || !ok) begin n_err++; $display("FAIL empty_writes got %0d want 0", cap_a.size()); end
        bus_write(CFG + 32'd12, 32'h2, 4'h1);
    endtask

    task automatic test_stall();
        stall_idx = 1; stall_len = 5;
        test_fill("stall", 5, 3, 3, 1, 32'h00C0FFEE, 1'b0, 1'b0);
        n_vec++; if (stall_hi < 6) begin n_err++; $display("FAIL stall_len got %0d cycles want >=6", stall_hi); end
        stall_idx = -1; stall_len = 0;
    endtask

    task automatic test_start_busy();
        bit ok;
        logic [31:0] d;
        model_fill(2, 2, 4, 2, 32'h00ABCDEF, 1'b1, 1'b0);
        start_fill(2, 2, 4, 2, 32'h00ABCDEF, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        bus_write(CFG + 32'd4, 32'h01010000, 4'hF);
        bus_write(CFG + 32'd8, 32'h00FFFFFF, 4'hF);
        bus_write(CFG, 32'h7, 4'h1);
        wait_idle(ok);
        n_vec++; if (!ok || cap_a.size() != exp_a.size()) begin
            n_err++; $display("FAIL busy_count got %0d want %0d", cap_a.size(), exp_a.size());
        end
        for (int i = 0; i < exp_a.size() && i < cap_a.size(); i++) begin
            n_vec++;
            if ({cap_a[i], cap_d[i], cap_m[i]} !== {exp_a[i], exp_d[i], exp_m[i]}) begin
                n_err++; $display("FAIL busy_wr%0d got %h/%h want %h/%h", i, cap_a[i], cap_d[i], exp_a[i], exp_d[i]);
            end
        end
        bus_read(CFG + 32'd12, d);
        n_vec++; if (d !== 32'h6) begin n_err++; $display("FAIL busy_err_status got %h want 6", d); end
        bus_write(CFG + 32'd12, 32'h6, 4'h1);
        bus_read(CFG + 32'd12, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL status_clear got %h want 0", d); end
    endtask

    task automatic test_random();
        int x0, y0, w, h;
        for (int it = 0; it < 10; it++) begin
            rand_rdy = 1'b1;
            x0 = $urandom_range(0, 70); y0 = $urandom_range(0, 70);
            w  = $urandom_range(0, 12); h  = $urandom_range(0, 5);
            test_fill("rand", x0, y0, w, h, $urandom, 1'($urandom), 1'($urandom));
        end
        rand_rdy = 1'b0;
    endtask

    task automatic test_reset_midfill();
        int n;
        logic [31:0] d;
        start_fill(0, 0, 10, 4, 32'h00555555, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !m_wen; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++; if (m_wen !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL midrst_drop got m_wen=%b busy=%b want 0/0", m_wen, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        n = cap_a.size();
        repeat (20) @(negedge clk);
        n_vec++; if (cap_a.size() != n || m_wen !== 1'b0) begin
            n_err++; $display("FAIL midrst_writes got %0d want %0d", cap_a.size(), n);
        end
        bus_read(CFG + 32'd12, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL midrst_status got %h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_swap();
        test_clip();
        test_empty();
        test_stall();
        test_start_busy();
        test_random();
        test_reset_midfill();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
